// File: rtl/hazard_ctrl.sv
// Hazard control beside the ID/EX boundary of the 5-stage RV32I pipeline: load-use stall,
// taken-branch flush and data-memory freeze. Optional perf counters behind HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_memread,
  input  logic                      id_regwrite,
  input  logic                      ex_branch_taken,
  input  logic                      mem_busy,
  output logic                      stall,
  output logic                      pc_we,
  output logic                      ifid_we,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t                    r_state;
  logic [2:0]                r_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
  logic                      r_ex_memread;
  logic                      r_ex_regwrite;
  logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
  logic                      r_mem_regwrite;

  logic w_load_use;
  logic w_flush_evt;

  assign w_load_use = r_ex_memread && (r_ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == r_ex_rd)));

  // A taken branch only starts a flush from RUN and only when MEM is not holding.
  assign w_flush_evt = (r_state == S_RUN) && !mem_busy && ex_branch_taken;

  always_comb begin
    stall      = 1'b0;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_busy) begin
          stall   = 1'b1;
          pc_we   = 1'b0;
          ifid_we = 1'b0;
        end else if (ex_branch_taken) begin
          stall      = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_load_use) begin
          stall      = 1'b1;
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      S_FLUSH: begin
        stall      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (mem_busy) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // r_cnt holds the FLUSH cycles still to run, counting the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_flush_evt && (FLUSH_CYCLES > 1)) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNT_INIT;
          end
        end
        S_FLUSH: begin
          if (!mem_busy) begin
            if (r_cnt <= 3'd1) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd        <= '0;
      r_ex_memread   <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
    end else if (!mem_busy) begin
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      if (idex_flush) begin
        r_ex_rd       <= '0;
        r_ex_memread  <= 1'b0;
        r_ex_regwrite <= 1'b0;
      end else begin
        r_ex_rd       <= id_rd;
        r_ex_memread  <= id_memread;
        r_ex_regwrite <= id_regwrite;
      end
    end
  end

  // MEM-stage shadow is a tap for forwarding logic; nothing in this block consumes it.
  logic w_unused_fwd_tap;
  assign w_unused_fwd_tap = ^{r_mem_rd, r_mem_regwrite};

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      if (w_flush_evt && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected control outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_memread, id_regwrite;
  logic        ex_branch_taken, mem_busy;
  logic        stall, pc_we, ifid_we, ifid_flush, idex_flush;
  logic [31:0] stall_count, flush_count;

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_memread(id_memread), .id_regwrite(id_regwrite),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, pc_we, ifid_we, ifid_flush, idex_flush}
  localparam logic [4:0] PASS = 5'b01100;
  localparam logic [4:0] LU   = 5'b10001;
  localparam logic [4:0] BR   = 5'b11111;
  localparam logic [4:0] FRZ  = 5'b10000;
  localparam logic [4:0] FLB  = 5'b10011;

  typedef struct {
    string       nm;
    logic [4:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] e_sc = 0;
  logic [31:0] e_fc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rstn,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic rw,
                      input logic br, input logic busy,
                      input logic [4:0] ctl, input logic fc_inc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_memread = mr; id_regwrite = rw; ex_branch_taken = br; mem_busy = busy;
    if (!rstn) begin
      e_sc = 0;
      e_fc = 0;
    end
    e.nm = nm;
    e.ctl = ctl;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = e_sc;
    e.fc = e_fc;
`else
    e.sc = 0;
    e.fc = 0;
`endif
    q.push_back(e);
    if (rstn) begin
      if (ctl[4]) e_sc = e_sc + 1;
      if (fc_inc) e_fc = e_fc + 1;
    end
  endtask

  task automatic idle(input string nm, input logic [4:0] ctl);
    step(nm, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".stall"},       32'(stall),      32'(e.ctl[4]));
        chk({e.nm, ".pc_we"},       32'(pc_we),      32'(e.ctl[3]));
        chk({e.nm, ".ifid_we"},     32'(ifid_we),    32'(e.ctl[2]));
        chk({e.nm, ".ifid_flush"},  32'(ifid_flush), 32'(e.ctl[1]));
        chk({e.nm, ".idex_flush"},  32'(idex_flush), 32'(e.ctl[0]));
        chk({e.nm, ".stall_count"}, stall_count,     e.sc);
        chk({e.nm, ".flush_count"}, flush_count,     e.fc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_memread = 1'b0; id_regwrite = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

    //   name          rstn rs1  u1 rs2   u2 rd    mr rw br busy  ctl  fc
    step("reset",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0,   PASS, 0);
    idle("idle0", PASS);
    // lw x5 then add x6,x5,x1: one bubble, then pass
    step("lw_x5",      1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0,   PASS, 0);
    step("use_rs1",    1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 1, 0, 0,   LU,   0);
    step("use_rs1_ok", 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 1, 0, 0,   PASS, 0);
    // rs2 path
    step("lw_x7",      1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0,   PASS, 0);
    step("use_rs2",    1, 5'd3, 1, 5'd7, 1, 5'd8, 0, 1, 0, 0,   LU,   0);
    step("use_rs2_ok", 1, 5'd3, 1, 5'd7, 1, 5'd8, 0, 1, 0, 0,   PASS, 0);
    // matching rs1 but not read: no hazard
    step("lw_x9",      1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0, 0,   PASS, 0);
    step("nouse_rs1",  1, 5'd9, 0, 5'd2, 1, 5'd10, 0, 1, 0, 0,  PASS, 0);
    // x0 never hazards
    step("lw_x0",      1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 0,   PASS, 0);
    step("use_x0",     1, 5'd0, 1, 5'd0, 1, 5'd11, 0, 1, 0, 0,  PASS, 0);
    idle("idle1", PASS);
    // taken branch: two flush cycles then RUN
    step("br",         1, 5'd0, 0, 5'd0, 0, 5'd12, 0, 1, 1, 0,  BR,   1);
    idle("flush1", BR);
    idle("after_br", PASS);
    // branch, then mem_busy for 3 cycles in FLUSH (branch pulses ignored)
    step("br2",        1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0,   BR,   1);
    step("flb1",       1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1,   FLB,  0);
    step("flb2",       1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1,   FLB,  0);
    step("flb3",       1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1,   FLB,  0);
    step("fl_br_ign",  1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0,   BR,   0);
    idle("after_br2", PASS);
    // freeze in RUN beats load-use; shadows hold so the hazard fires afterwards
    step("lw_x4",      1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0, 0,   PASS, 0);
    step("frz_lu",     1, 5'd4, 1, 5'd0, 0, 5'd13, 0, 1, 0, 1,  FRZ,  0);
    step("lu_after",   1, 5'd4, 1, 5'd0, 0, 5'd13, 0, 1, 0, 0,  LU,   0);
    step("lu_done",    1, 5'd4, 1, 5'd0, 0, 5'd13, 0, 1, 0, 0,  PASS, 0);
    // busy beats branch in RUN: no flush counted
    step("frz_br",     1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1,   FRZ,  0);
    // simultaneous branch and load-use: flush only
    step("lw_x3",      1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0, 0,   PASS, 0);
    step("br_lu",      1, 5'd3, 1, 5'd0, 0, 5'd14, 0, 1, 1, 0,  BR,   1);
    idle("br_lu_fl", BR);
    idle("br_lu_done", PASS);
    // reset mid-FLUSH
    step("br3",        1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0,   BR,   1);
    step("rst_mid",    0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0,   PASS, 0);
    idle("post_rst", PASS);
    step("post_rst_br",1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0,   BR,   1);
    idle("post_rst_fl", BR);
    idle("end", PASS);

    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
